// File: rtl/led_ctrl_pkg.sv
// Shared types and field layout for the LED pattern controller.
package led_ctrl_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned MODE_LSB  = 0;
    localparam int unsigned PARAM_LSB = MODE_LSB + MODE_W;
    // Stored param width; covers the widest supported PWM_BITS
    localparam int unsigned PARAM_W   = 16;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e               mode;
        logic [PARAM_W-1:0]  param;
    } chan_cfg_t;

endpackage

// File: rtl/led_tick_gen.sv
// Shared prescaler: one-cycle tick every TICK_DIV cycles while enabled.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    // Disabling clears the count so the next enable restarts a full period
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else begin
            tick_d = wrap;
            cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED controller: per-channel OFF/ON/BLINK/PWM on a shared time base.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter  int unsigned N_LED    = 4,
    parameter  int unsigned TICK_DIV = 5,
    parameter  int unsigned PWM_BITS = 4,
    localparam int unsigned AW       = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [PWM_BITS+1:0]   cfg_wdata,
    output logic [N_LED-1:0]      led,
    output logic                  tick_o
);

    localparam int unsigned AW1 = AW + 1;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                wr_ok;
    chan_cfg_t           wr_cfg;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick_o)
    );

    // Shared PWM phase advances once per tick
    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (tick_o) begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end
    end

    assign wr_ok       = cfg_we && ({1'b0, cfg_addr} < AW1'(N_LED));
    assign wr_cfg.mode  = mode_e'(cfg_wdata[MODE_LSB +: MODE_W]);
    assign wr_cfg.param = PARAM_W'(cfg_wdata[PARAM_LSB +: PWM_BITS]);

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        chan_cfg_t           cfg_q, cfg_d;
        logic [PWM_BITS-1:0] blink_cnt_q, blink_cnt_d, blink_cnt_nxt;
        logic                blink_q, blink_d, blink_nxt;
        logic                wr_hit;
        logic                led_bit_d;

        assign wr_hit = wr_ok && (cfg_addr == AW'(i));

        // LED follows the tick-advanced blink/PWM state but the pre-write config,
        // so a write becomes visible one edge after it lands
        always_comb begin
            blink_cnt_nxt = blink_cnt_q;
            blink_nxt     = blink_q;
            if (tick_o && (cfg_q.mode == MODE_BLINK)) begin
                if (PARAM_W'(blink_cnt_q) == cfg_q.param) begin
                    blink_cnt_nxt = '0;
                    blink_nxt     = ~blink_q;
                end else begin
                    blink_cnt_nxt = blink_cnt_q + PWM_BITS'(1);
                end
            end

            cfg_d       = cfg_q;
            blink_cnt_d = blink_cnt_nxt;
            blink_d     = blink_nxt;
            if (wr_hit) begin
                cfg_d       = wr_cfg;
                blink_cnt_d = '0;
                blink_d     = 1'b0;
            end

            led_bit_d = 1'b0;
            case (cfg_q.mode)
                MODE_ON:    led_bit_d = 1'b1;
                MODE_BLINK: led_bit_d = blink_nxt;
                MODE_PWM:   led_bit_d = (PARAM_W'(pwm_cnt_d) < cfg_q.param);
                default:    led_bit_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cfg_q       <= '{mode: MODE_OFF, param: '0};
                blink_cnt_q <= '0;
                blink_q     <= 1'b0;
            end else begin
                cfg_q       <= cfg_d;
                blink_cnt_q <= blink_cnt_d;
                blink_q     <= blink_d;
            end
        end

        assign led_d[i] = led_bit_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: 4-channel main instance plus a 3-channel instance.
module tb_led_pattern_ctrl;

    logic       clk;
    logic       rst_n, enable, cfg_we;
    logic [1:0] cfg_addr;
    logic [5:0] cfg_wdata;
    logic [3:0] led;
    logic       tick_o;

    logic       rst3_n, en3, we3;
    logic [1:0] addr3;
    logic [5:0] wdata3;
    logic [2:0] led3;
    logic       tick3;

    int comps = 0;
    int fails = 0;
    int cyc   = 0;

    led_pattern_ctrl #(.N_LED(4), .TICK_DIV(5), .PWM_BITS(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .led       (led),
        .tick_o    (tick_o)
    );

    led_pattern_ctrl #(.N_LED(3), .TICK_DIV(5), .PWM_BITS(4)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst3_n),
        .enable    (en3),
        .cfg_we    (we3),
        .cfg_addr  (addr3),
        .cfg_wdata (wdata3),
        .led       (led3),
        .tick_o    (tick3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_wr(input logic [1:0] a, input logic [5:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    // Ticks are consumed on edges 6, 11, 16, ... after reset release with enable held high
    function automatic int consumes(input int c, input int w);
        return (c - 1) / 5 - (w - 1) / 5;
    endfunction

    function automatic logic blink_exp(input int c, input int w, input int p);
        return ((consumes(c, w) / (p + 1)) % 2) == 1;
    endfunction

    function automatic int pwm_at(input int c);
        return ((c - 1) / 5) % 16;
    endfunction

    task automatic test_reset();
        logic exp_t;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        comps++; if (led !== 4'b0000) begin fails++; $display("FAIL reset_led got=%b want=%b", led, 4'b0000); end
        comps++; if (tick_o !== 1'b0) begin fails++; $display("FAIL reset_tick got=%b want=0", tick_o); end
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            exp_t = (cyc % 5 == 0);
            comps++; if (led !== 4'b0000) begin fails++; $display("FAIL idle_led cyc=%0d got=%b want=0000", cyc, led); end
            comps++; if (tick_o !== exp_t) begin fails++; $display("FAIL idle_tick cyc=%0d got=%b want=%b", cyc, tick_o, exp_t); end
        end
    endtask

    task automatic test_on();
        drive_wr(2'd0, 6'b000001);
        comps++; if (led !== 4'b0000) begin fails++; $display("FAIL on_write_edge got=%b want=0000", led); end
        step();
        comps++; if (led !== 4'b0001) begin fails++; $display("FAIL on_visible got=%b want=0001", led); end
    endtask

    task automatic test_blink();
        logic [3:0] e;
        logic       exp_t;
        drive_wr(2'd1, 6'b000110);
        while (cyc < 100) begin
            step();
            e     = {2'b00, blink_exp(cyc, 53, 1), 1'b1};
            exp_t = (cyc % 5 == 0);
            comps++; if (led !== e) begin fails++; $display("FAIL blink cyc=%0d got=%b want=%b", cyc, led, e); end
            comps++; if (tick_o !== exp_t) begin fails++; $display("FAIL blink_tick cyc=%0d got=%b want=%b", cyc, tick_o, exp_t); end
        end
    endtask

    task automatic test_pwm_param(input logic [3:0] p, input int exp_hi);
        logic [3:0] e;
        int         hi;
        hi = 0;
        drive_wr(2'd2, {p, 2'b11});
        for (int i = 0; i < 80; i++) begin
            step();
            e = {1'b0, (pwm_at(cyc) < int'(p)), blink_exp(cyc, 53, 1), 1'b1};
            comps++; if (led !== e) begin fails++; $display("FAIL pwm_p%0d cyc=%0d got=%b want=%b", p, cyc, led, e); end
            if (cyc % 5 == 1 && led[2] === 1'b1) hi++;
        end
        comps++; if (hi !== exp_hi) begin fails++; $display("FAIL pwm_duty_p%0d got=%0d want=%0d", p, hi, exp_hi); end
    endtask

    task automatic test_pwm();
        test_pwm_param(4'd4, 4);
        test_pwm_param(4'd0, 0);
        test_pwm_param(4'd15, 15);
    endtask

    task automatic test_collision_enable();
        logic [3:0] e;
        logic       exp_t, l1;
        step();
        step();
        comps++; if (tick_o !== 1'b1) begin fails++; $display("FAIL coll_tick_pre cyc=%0d got=%b want=1", cyc, tick_o); end
        drive_wr(2'd1, 6'b000110);
        while (cyc < 363) begin
            step();
            e = {1'b0, (pwm_at(cyc) < 15), blink_exp(cyc, 346, 1), 1'b1};
            comps++; if (led !== e) begin fails++; $display("FAIL coll cyc=%0d got=%b want=%b", cyc, led, e); end
        end
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cyc == 370) begin
                cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 6'b000001;
            end else begin
                cfg_we = 1'b0;
            end
            e = (cyc >= 372) ? 4'b1111 : 4'b0111;
            comps++; if (led !== e) begin fails++; $display("FAIL frozen_led cyc=%0d got=%b want=%b", cyc, led, e); end
            comps++; if (tick_o !== 1'b0) begin fails++; $display("FAIL frozen_tick cyc=%0d got=%b want=0", cyc, tick_o); end
        end
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_t = (cyc >= 388) && ((cyc - 388) % 5 == 0);
            l1    = (cyc < 389) ? 1'b1 : ((cyc < 399) ? 1'b0 : 1'b1);
            e     = {2'b11, l1, 1'b1};
            comps++; if (tick_o !== exp_t) begin fails++; $display("FAIL resume_tick cyc=%0d got=%b want=%b", cyc, tick_o, exp_t); end
            comps++; if (led !== e) begin fails++; $display("FAIL resume_led cyc=%0d got=%b want=%b", cyc, led, e); end
        end
    endtask

    task automatic test_bad_addr_reset();
        logic [2:0] e;
        logic       exp_t;
        int         k;
        rst3_n = 1'b1;
        k      = 0;
        we3 = 1'b1; addr3 = 2'd0; wdata3 = 6'b000001; step(); k++;
        addr3 = 2'd1; wdata3 = 6'b000010; step(); k++;
        addr3 = 2'd2; wdata3 = 6'b001011; step(); k++;
        addr3 = 2'd3; wdata3 = 6'b000010; step(); k++;
        we3 = 1'b0;
        while (k < 40) begin
            step(); k++;
            e     = {(pwm_at(k) < 2), (((k - 1) / 5) % 2 == 1), 1'b1};
            exp_t = (k % 5 == 0);
            comps++; if (led3 !== e) begin fails++; $display("FAIL badaddr_led k=%0d got=%b want=%b", k, led3, e); end
            comps++; if (tick3 !== exp_t) begin fails++; $display("FAIL badaddr_tick k=%0d got=%b want=%b", k, tick3, exp_t); end
        end
        #2 rst3_n = 1'b0;
        #1;
        comps++; if (led3 !== 3'b000) begin fails++; $display("FAIL async_rst_led got=%b want=000", led3); end
        comps++; if (tick3 !== 1'b0) begin fails++; $display("FAIL async_rst_tick got=%b want=0", tick3); end
        step();
        step();
        rst3_n = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step();
            exp_t = (j % 5 == 0);
            comps++; if (led3 !== 3'b000) begin fails++; $display("FAIL post_rst_led k=%0d got=%b want=000", j, led3); end
            comps++; if (tick3 !== exp_t) begin fails++; $display("FAIL post_rst_tick k=%0d got=%b want=%b", j, tick3, exp_t); end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        rst3_n = 1'b0; en3 = 1'b1; we3 = 1'b0; addr3 = '0; wdata3 = '0;
        test_reset();
        test_on();
        test_blink();
        test_pwm();
        test_collision_enable();
        test_bad_addr_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end

endmodule
